// File: rtl/rand_arb_pkg.sv
// Shared types and constants for the rand32 arbiter slice.
package rand_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rand32_arbiter_if.sv
// Client/generator bundle of the rand32 arbiter; master = client+generator side, slave = arbiter.
interface rand32_arbiter_if #(
  parameter int NUM_CLIENTS = 4
) ();

  logic [NUM_CLIENTS-1:0] REQ_VALID;
  logic [NUM_CLIENTS-1:0] REQ_READY;
  logic [NUM_CLIENTS-1:0] RESP_VALID;
  logic [NUM_CLIENTS-1:0] RESP_READY;
  logic [31:0]            RESP_DATA;
  logic                   RAND_REQ;
  logic [31:0]            RAND_DATA;
  logic                   BUSY;

  modport master (
    output REQ_VALID, RESP_READY, RAND_DATA,
    input  REQ_READY, RESP_VALID, RESP_DATA, RAND_REQ, BUSY
  );

  modport slave (
    input  REQ_VALID, RESP_READY, RAND_DATA,
    output REQ_READY, RESP_VALID, RESP_DATA, RAND_REQ, BUSY
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after the last winner, wrapping around.
module rr_pick #(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   any_o
);

  logic [IDX_W-1:0] cand_s;

  // Scan offsets 1..NUM_CLIENTS from last; the last winner is checked only after everyone else.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_s = '0;
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      cand_s = IDX_W'((int'(last_i) + off) % NUM_CLIENTS);
      if (!any_o && req_i[cand_s]) begin
        any_o         = 1'b1;
        idx_o         = cand_s;
        gnt_o[cand_s] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/rand32_arbiter.sv
// Shares one 32-bit random generator among NUM_CLIENTS requesters, one transaction at a time.
module rand32_arbiter
  import rand_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int LATENCY     = 1
) (
  input  logic           CLK,
  input  logic           RESET,
  rand32_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [31:0]            resp_data_q, resp_data_d;

  logic [NUM_CLIENTS-1:0] pick_gnt_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_any_s;
  logic [NUM_CLIENTS-1:0] req_ready_s;
  logic [NUM_CLIENTS-1:0] resp_valid_s;
  logic                   rand_req_s;

  rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req_i  (bus.REQ_VALID),
    .last_i (last_q),
    .gnt_o  (pick_gnt_s),
    .idx_o  (pick_idx_s),
    .any_o  (pick_any_s)
  );

  // Next-state and handshake outputs of the grant/wait/respond sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    last_d       = last_q;
    resp_data_d  = resp_data_q;
    req_ready_s  = '0;
    resp_valid_s = '0;
    rand_req_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          req_ready_s = pick_gnt_s;
          rand_req_s  = 1'b1;
          winner_d    = pick_idx_s;
          cnt_d       = CNT_W'(LATENCY);
          state_d     = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Generator word is valid in the cycle the count reaches 1.
        if (cnt_q <= CNT_W'(1)) begin
          resp_data_d = bus.RAND_DATA;
          cnt_d       = CNT_W'(0);
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid_s[winner_q] = 1'b1;
        if (bus.RESP_READY[winner_q]) begin
          last_d  = winner_q;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
  end

  // State, counter, winner/last and response-data registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_W'(0);
      winner_q    <= IDX_W'(0);
      last_q      <= IDX_W'(NUM_CLIENTS - 1);
      resp_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Grant strobes are combinational from IDLE, so reset must mask them directly.
  assign bus.REQ_READY  = req_ready_s & {NUM_CLIENTS{RESET}};
  assign bus.RAND_REQ   = rand_req_s & RESET;
  assign bus.RESP_VALID = resp_valid_s;
  assign bus.RESP_DATA  = resp_data_q;
  assign bus.BUSY       = (state_q != IDLE);

endmodule

// File: doc/rand32_arbiter.md
RAND32_ARBITER -- requirements
Module: rand32_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 4, number of requesters sharing one 32-bit random source (legal 2..8).
REQ-002 Parameter LATENCY, default 1, cycles from a RAND_REQ pulse to valid RAND_DATA (legal 1..15).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 REQ_VALID  input  NUM_CLIENTS  per-client request for one random word.
REQ-006 REQ_READY  output  NUM_CLIENTS  one-hot accept pulse; request consumed when REQ_VALID[i] & REQ_READY[i].
REQ-007 RESP_VALID  output  NUM_CLIENTS  one-hot; RESP_DATA valid for client i.
REQ-008 RESP_READY  input  NUM_CLIENTS  per-client response acceptance.
REQ-009 RESP_DATA  output  32  random word delivered to the granted client.
REQ-010 RAND_REQ  output  1  one-cycle pulse advancing the shared generator.
REQ-011 RAND_DATA  input  32  generator output, sampled LATENCY cycles after RAND_REQ.
REQ-012 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-013 Three-state FSM: IDLE, WAIT, RESP.
REQ-014 IDLE, no REQ_VALID: stay in IDLE; all outputs except RESP_DATA low.
REQ-015 IDLE, any REQ_VALID: pick winner g round-robin, searching from (last+1) mod NUM_CLIENTS upward; in that same cycle REQ_READY[g]=1 and RAND_REQ=1; latch g; load counter=LATENCY; go to WAIT.
REQ-016 WAIT: decrement counter each cycle; in the cycle the counter equals 1, capture RAND_DATA into RESP_DATA register; go to RESP next cycle.
REQ-017 Timing: grant in cycle t; capture at end of cycle t+LATENCY; RESP_VALID[g] high from cycle t+LATENCY+1.
REQ-018 RESP: RESP_VALID[g]=1, RESP_DATA stable until RESP_READY[g]=1; on handshake set last=g, go to IDLE.
REQ-019 RESP_READY of non-granted clients is ignored in every state.
REQ-020 REQ_READY and RAND_REQ are asserted only in IDLE, at most one cycle per transaction; never asserted while in WAIT or RESP.
REQ-021 A client that deasserts REQ_VALID before being granted loses no state; no request is ever queued.
REQ-022 Minimum transaction period is LATENCY+2 cycles (grant, LATENCY wait, 1 response cycle), with arbitration in the cycle following the RESP handshake.
REQ-023 A granted client is not re-granted while any other client has REQ_VALID high at arbitration (starvation-free).
REQ-024 RESP_DATA holds its last value when the FSM is not in RESP.

Reset
REQ-025 RESET low asynchronously forces: state=IDLE, counter=0, RESP_DATA=0, last=NUM_CLIENTS-1 (client 0 wins first), and all REQ_READY, RESP_VALID, RAND_REQ and BUSY outputs low.
REQ-026 Reset asserted mid-transaction abandons it: no response is delivered, and the in-flight generator word is discarded.
REQ-027 On reset release, first arbitration occurs at the first rising edge with RESET high.

Structure
REQ-028 Shared package rand_arb_pkg holds the state enum typedef (IDLE, WAIT, RESP) and constant CNT_W=4.
REQ-029 One sub-module rr_pick: combinational round-robin picker (inputs: request vector, last index; outputs: one-hot grant, winner index, any).
REQ-030 FSM, counter, winner/last registers and RESP_DATA register reside in rand32_arbiter.

Verification
REQ-031 Single client: LATENCY=1, REQ_VALID=0001 at t0 -> REQ_READY=0001 and RAND_REQ at t0; RESP_VALID=0001 at t0+2 with RESP_DATA = RAND_DATA from t0+1.
REQ-032 All four clients request continuously with RESP_READY=1111 -> grant order 0,1,2,3,0, one grant every LATENCY+2 cycles.
REQ-033 LATENCY=3, RESP_READY[g] held low 5 cycles -> RESP_VALID and RESP_DATA stable throughout; no RAND_REQ during the hold.
REQ-034 Clients 1 and 3 request after last=3 -> client 1 wins; next grant goes to 3 even though 1 re-requests.
REQ-035 RESET driven low during WAIT -> all outputs low immediately; after release with REQ_VALID=0100, client 2 is granted at the first edge.
REQ-036 RESP_READY asserted for a non-granted client during RESP -> no state change; response remains pending.
